// File: rtl/nv_nvdla_cmac_slcg_en_ctrl.sv
// CMAC second-level clock-gate enable: a wake/hold FSM opens the gated clock ahead of work
// and closes it after a programmable idle hold. Overrides and test disables force it open.
module nv_nvdla_cmac_slcg_en_ctrl #(
  parameter int CNT_W    = 8,
  parameter int WAKE_CYC = 2,
  parameter int PERF_W   = 16
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              dla_clk_ovr_on,
  input  logic              global_clk_ovr_on,
  input  logic              tmc2slcg_disable_clock_gating,
  input  logic              cfg_slcg_dis,
  input  logic [CNT_W-1:0]  cfg_idle_hold,
  input  logic              op_en,
  input  logic              req_valid,
  input  logic              core_busy,
  output logic              slcg_en,
  output logic              wake_rdy,
  output logic              dla_clk_ovr_on_sync,
  output logic              global_clk_ovr_on_sync,
  output logic [PERF_W-1:0] slcg_wake_cnt
);

  typedef enum logic [1:0] {S_OFF, S_WAKE, S_ON, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PERF_W-1:0]   wake_cnt_q, wake_cnt_d;
  logic                dla_s1_q, dla_s2_q;
  logic                glb_s1_q, glb_s2_q;
  logic                slcg_en_q, wake_rdy_q;
  logic                activity;
  logic                force_on;

  assign activity = op_en | req_valid | core_busy;
  // Test-mode disable is static, so it is used without synchronization.
  assign force_on = dla_s2_q | glb_s2_q | tmc2slcg_disable_clock_gating | cfg_slcg_dis;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      S_OFF: begin
        if (activity) begin
          state_d = S_WAKE;
          cnt_d   = WAKE_LOAD;
          if (!(&wake_cnt_q)) wake_cnt_d = wake_cnt_q + PERF_W'(1);
        end
      end
      S_WAKE: begin
        if (cnt_q == '0) state_d = S_ON;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_ON: begin
        if (!activity) begin
          if (cfg_idle_hold == '0) begin
            state_d = S_OFF;
          end else begin
            state_d = S_HOLD;
            cnt_d   = cfg_idle_hold - CNT_W'(1);
          end
        end
      end
      S_HOLD: begin
        // Renewed activity wins over hold expiry.
        if (activity)            state_d = S_ON;
        else if (cnt_q == '0)    state_d = S_OFF;
        else                     cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q    <= S_OFF;
      cnt_q      <= '0;
      wake_cnt_q <= '0;
      dla_s1_q   <= 1'b0;
      dla_s2_q   <= 1'b0;
      glb_s1_q   <= 1'b0;
      glb_s2_q   <= 1'b0;
      slcg_en_q  <= 1'b0;
      wake_rdy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wake_cnt_q <= wake_cnt_d;
      dla_s1_q   <= dla_clk_ovr_on;
      dla_s2_q   <= dla_s1_q;
      glb_s1_q   <= global_clk_ovr_on;
      glb_s2_q   <= glb_s1_q;
      // Registered from next state so the SLCG cell never sees a combinational path.
      slcg_en_q  <= (state_d != S_OFF) | force_on;
      wake_rdy_q <= (state_d == S_ON) | (state_d == S_HOLD) | force_on;
    end
  end

  assign slcg_en                = slcg_en_q;
  assign wake_rdy               = wake_rdy_q;
  assign dla_clk_ovr_on_sync    = dla_s2_q;
  assign global_clk_ovr_on_sync = glb_s2_q;
  assign slcg_wake_cnt          = wake_cnt_q;

endmodule

// File: tb/tb_nv_nvdla_cmac_slcg_en_ctrl.sv
// Scoreboard bench for the CMAC SLCG enable controller: directed cycles push expected outputs,
// a monitor pops and compares them on the falling edge.
module tb_nv_nvdla_cmac_slcg_en_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dla_ovr = 1'b0, glb_ovr = 1'b0, tmc_dis = 1'b0, cfg_dis = 1'b0;
  logic [7:0]  cfg_idle_hold = 8'd0;
  logic        op_en = 1'b0, req_valid = 1'b0, core_busy = 1'b0;

  logic        slcg_en, wake_rdy, ds, gs;
  logic [15:0] wake_cnt;
  logic        sat_en, sat_rdy, sat_ds, sat_gs;
  logic [3:0]  sat_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [15:0] exp_wc = 16'd0;

  typedef struct {
    int          stamp;
    string       name;
    logic        en;
    logic        rdy;
    logic        ds;
    logic        gs;
    logic [15:0] wc;
  } exp_t;

  exp_t sb[$];

  nv_nvdla_cmac_slcg_en_ctrl #(.CNT_W(8), .WAKE_CYC(2), .PERF_W(16)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
    .dla_clk_ovr_on(dla_ovr), .global_clk_ovr_on(glb_ovr),
    .tmc2slcg_disable_clock_gating(tmc_dis), .cfg_slcg_dis(cfg_dis),
    .cfg_idle_hold(cfg_idle_hold), .op_en(op_en), .req_valid(req_valid), .core_busy(core_busy),
    .slcg_en(slcg_en), .wake_rdy(wake_rdy),
    .dla_clk_ovr_on_sync(ds), .global_clk_ovr_on_sync(gs), .slcg_wake_cnt(wake_cnt)
  );

  // Narrow perf counter instance so saturation is reachable in a short run.
  nv_nvdla_cmac_slcg_en_ctrl #(.CNT_W(8), .WAKE_CYC(2), .PERF_W(4)) dut_sat (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
    .dla_clk_ovr_on(dla_ovr), .global_clk_ovr_on(glb_ovr),
    .tmc2slcg_disable_clock_gating(tmc_dis), .cfg_slcg_dis(cfg_dis),
    .cfg_idle_hold(cfg_idle_hold), .op_en(op_en), .req_valid(req_valid), .core_busy(core_busy),
    .slcg_en(sat_en), .wake_rdy(sat_rdy),
    .dla_clk_ovr_on_sync(sat_ds), .global_clk_ovr_on_sync(sat_gs), .slcg_wake_cnt(sat_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Drive the current inputs across one rising edge and queue the outputs expected after it.
  task automatic step(input string nm, input logic en, input logic rdy, input logic eds, input logic egs);
    exp_t e;
    e.stamp = cyc + 1;
    e.name  = nm;
    e.en    = en;
    e.rdy   = rdy;
    e.ds    = eds;
    e.gs    = egs;
    e.wc    = exp_wc;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].stamp <= cyc) begin
        e = sb.pop_front();
        chk({e.name, ".slcg_en"},  {31'd0, slcg_en},  {31'd0, e.en});
        chk({e.name, ".wake_rdy"}, {31'd0, wake_rdy}, {31'd0, e.rdy});
        chk({e.name, ".dla_sync"}, {31'd0, ds},       {31'd0, e.ds});
        chk({e.name, ".glb_sync"}, {31'd0, gs},       {31'd0, e.gs});
        chk({e.name, ".wake_cnt"}, {16'd0, wake_cnt}, {16'd0, e.wc});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    chk("rst.slcg_en",  {31'd0, slcg_en},  32'd0);
    chk("rst.wake_rdy", {31'd0, wake_rdy}, 32'd0);
    chk("rst.wake_cnt", {16'd0, wake_cnt}, 32'd0);
    rst_n = 1'b1;

    step("idle", 0, 0, 0, 0);

    // One-cycle request pulse: enable next edge, ready WAKE_CYC edges later, then 4-cycle hold.
    cfg_idle_hold = 8'd4;
    req_valid = 1'b1; exp_wc = 16'd1;
    step("pulse_en", 1, 0, 0, 0);
    req_valid = 1'b0;
    step("pulse_wake", 1, 0, 0, 0);
    step("pulse_rdy", 1, 1, 0, 0);
    step("hold0", 1, 1, 0, 0);
    step("hold1", 1, 1, 0, 0);
    step("hold2", 1, 1, 0, 0);
    step("hold3", 1, 1, 0, 0);
    step("hold_off", 0, 0, 0, 0);

    // Reactivation during hold; then a hold whose cfg changes mid-way.
    op_en = 1'b1; exp_wc = 16'd2;
    step("op_wake0", 1, 0, 0, 0);
    step("op_wake1", 1, 0, 0, 0);
    step("op_on", 1, 1, 0, 0);
    step("op_on2", 1, 1, 0, 0);
    op_en = 1'b0;
    step("rh0", 1, 1, 0, 0);
    step("rh1", 1, 1, 0, 0);
    step("rh2", 1, 1, 0, 0);
    op_en = 1'b1;
    step("react", 1, 1, 0, 0);
    op_en = 1'b0;
    step("s_hold0", 1, 1, 0, 0);
    cfg_idle_hold = 8'd0;
    step("s_hold1", 1, 1, 0, 0);
    step("s_hold2", 1, 1, 0, 0);
    step("s_hold3", 1, 1, 0, 0);
    step("s_off", 0, 0, 0, 0);

    // Zero idle hold: ON closes on the first idle edge.
    core_busy = 1'b1; exp_wc = 16'd3;
    step("z_wake0", 1, 0, 0, 0);
    core_busy = 1'b0;
    step("z_wake1", 1, 0, 0, 0);
    step("z_on", 1, 1, 0, 0);
    step("z_off", 0, 0, 0, 0);

    // Global override raised away from the clock edge while OFF.
    #2 glb_ovr = 1'b1;
    step("g_s1", 0, 0, 0, 0);
    step("g_s2", 0, 0, 0, 1);
    step("g_on", 1, 1, 0, 1);
    step("g_on2", 1, 1, 0, 1);
    #2 glb_ovr = 1'b0;
    step("g_d1", 1, 1, 0, 1);
    step("g_d2", 1, 1, 0, 0);
    step("g_off", 0, 0, 0, 0);

    // DLA override while the FSM still wakes and closes underneath it.
    dla_ovr = 1'b1;
    step("d_s1", 0, 0, 0, 0);
    step("d_s2", 0, 0, 1, 0);
    step("d_on", 1, 1, 1, 0);
    req_valid = 1'b1; exp_wc = 16'd4;
    step("fw0", 1, 1, 1, 0);
    req_valid = 1'b0;
    step("fw1", 1, 1, 1, 0);
    dla_ovr = 1'b0;
    step("fw2", 1, 1, 1, 0);
    step("fw3", 1, 1, 0, 0);
    step("fw4", 0, 0, 0, 0);

    // Unsynchronized test disable and register disable take effect on the next edge.
    tmc_dis = 1'b1;
    step("tmc_on", 1, 1, 0, 0);
    tmc_dis = 1'b0;
    step("tmc_off", 0, 0, 0, 0);
    cfg_dis = 1'b1;
    step("cfgdis_on", 1, 1, 0, 0);
    cfg_dis = 1'b0;
    step("cfgdis_off", 0, 0, 0, 0);

    // Asynchronous reset in the middle of HOLD.
    cfg_idle_hold = 8'd4;
    op_en = 1'b1; exp_wc = 16'd5;
    step("r_wake0", 1, 0, 0, 0);
    step("r_wake1", 1, 0, 0, 0);
    step("r_on", 1, 1, 0, 0);
    op_en = 1'b0;
    step("r_hold0", 1, 1, 0, 0);
    step("r_hold1", 1, 1, 0, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.slcg_en",  {31'd0, slcg_en},  32'd0);
    chk("arst.wake_rdy", {31'd0, wake_rdy}, 32'd0);
    chk("arst.wake_cnt", {16'd0, wake_cnt}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_wc = 16'd0;
    step("post_rst", 0, 0, 0, 0);

    // Repeated wake events: wide counter counts, narrow counter saturates at all-ones.
    cfg_idle_hold = 8'd0;
    for (int i = 0; i < 20; i++) begin
      req_valid = 1'b1; exp_wc = exp_wc + 16'd1;
      step("loop_en", 1, 0, 0, 0);
      req_valid = 1'b0;
      step("loop_wake", 1, 0, 0, 0);
      step("loop_on", 1, 1, 0, 0);
      step("loop_off", 0, 0, 0, 0);
      if (i == 7)  chk("sat.cnt8",  {28'd0, sat_cnt}, 32'd8);
      if (i == 14) chk("sat.cnt15", {28'd0, sat_cnt}, 32'd15);
    end
    chk("sat.hold", {28'd0, sat_cnt}, 32'd15);

    repeat (2) @(negedge clk);
    #1;
    chk("sb.drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
